pi_cmd_queue: RTL and testbench

//  Pi-side command front end for the 68k bus sequencer.
//  - Decodes Pi GPIO register accesses and builds complete bus commands.
//  - Posts them into a DEPTH-entry FIFO; the sequencer drains it over a valid/ready handshake.
//  - Returns read data and status to the Pi, so posted writes no longer stall the Pi for a full bus cycle.

---
 rtl/pi_cmd_queue.sv | 169 ++++++++++++++++
 tb/tb_pi_cmd_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_cmd_queue.sv
// Pi-side command front end: decodes Pi register writes into 68k bus commands,
// queues them for the bus sequencer and reports read data / status back to the Pi.
module pi_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        PI_CLK,
  input  logic        PI_RESET_n,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        PI_TXN_IN_PROGRESS,
  input  logic [2:0]  IPL_IN,
  output logic        OP_VALID,
  input  logic        OP_READY,
  output logic        OP_RW,
  output logic [23:0] OP_ADDR,
  output logic [15:0] OP_WDATA,
  output logic        OP_UDS_n,
  output logic        OP_LDS_n,
  input  logic        RD_DONE,
  input  logic [15:0] RD_DATA
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_ADDR_LO = 2'd1;
  localparam logic [1:0] A_ADDR_HI = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } cmd_t;

  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic                   wr_last_q, wr_last_d;
  cmd_t                   fifo_q [DEPTH];
  cmd_t                   fifo_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d, rd_queued_q, rd_queued_d;
  logic [7:0]             rd_inflight_q, rd_inflight_d;
  logic [15:0]            wdata_stage_q, wdata_stage_d;
  logic [15:0]            addr_lo_q, addr_lo_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   overflow_q, overflow_d;
  logic                   rd_err_q, rd_err_d;
  logic                   txn_q, txn_d;

  cmd_t        head, new_cmd;
  logic        wr_rise, push_req, status_wr, flush, pop, accept;
  logic        push_rd, pop_rd, done_ok;
  logic [15:0] status;

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], PI_WR};
    wr_last_d = wr_sync_q[SYNC_STAGES-1];
    wr_rise   = wr_sync_q[SYNC_STAGES-1] & ~wr_last_q;
    push_req  = wr_rise && (PI_A == A_ADDR_HI);
    status_wr = wr_rise && (PI_A == A_STATUS);
    flush     = status_wr && PI_D_IN[15];
    pop       = (count_q != '0) && OP_READY;
    accept    = push_req && !flush && ((count_q < CW'(DEPTH)) || pop);

    // Byte strobes follow address bit 0: odd byte on LDS, even byte on UDS.
    new_cmd.addr  = {PI_D_IN[7:0], addr_lo_q};
    new_cmd.wdata = wdata_stage_q;
    new_cmd.rw    = PI_D_IN[9];
    new_cmd.uds_n = PI_D_IN[8] & addr_lo_q[0];
    new_cmd.lds_n = PI_D_IN[8] & ~addr_lo_q[0];

    push_rd = accept && new_cmd.rw;
    pop_rd  = pop && head.rw;
    done_ok = RD_DONE && (rd_inflight_q != '0);

    fifo_d = fifo_q;
    if (accept) fifo_d[wr_ptr_q] = new_cmd;
    wr_ptr_d    = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(accept) - CW'(pop);
    rd_queued_d = rd_queued_q + CW'(push_rd) - CW'(pop_rd);
    // A read popped during a flush has already left for the bus, so it still goes in flight.
    rd_inflight_d = rd_inflight_q + 8'(pop_rd) - 8'(done_ok);
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_queued_d = '0;
    end

    wdata_stage_d = (wr_rise && PI_A == A_DATA) ? PI_D_IN : wdata_stage_q;
    addr_lo_d     = (wr_rise && PI_A == A_ADDR_LO) ? PI_D_IN : addr_lo_q;
    rdata_d       = RD_DONE ? RD_DATA : rdata_q;

    overflow_d = overflow_q;
    if (status_wr && PI_D_IN[0]) overflow_d = 1'b0;
    if (push_req && !flush && !accept) overflow_d = 1'b1;

    // A spurious completion arriving with a clear request still leaves the error visible.
    rd_err_d = rd_err_q;
    if (status_wr && PI_D_IN[1]) rd_err_d = 1'b0;
    if (RD_DONE && rd_inflight_q == '0) rd_err_d = 1'b1;

    txn_d = (rd_queued_d != '0) || (rd_inflight_d != '0) || (count_d == CW'(DEPTH));
  end

  always_ff @(posedge PI_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      wr_sync_q     <= '0;
      wr_last_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_queued_q   <= '0;
      rd_inflight_q <= '0;
      wdata_stage_q <= '0;
      addr_lo_q     <= '0;
      rdata_q       <= '0;
      overflow_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      txn_q         <= 1'b0;
    end else begin
      wr_sync_q     <= wr_sync_d;
      wr_last_q     <= wr_last_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_queued_q   <= rd_queued_d;
      rd_inflight_q <= rd_inflight_d;
      wdata_stage_q <= wdata_stage_d;
      addr_lo_q     <= addr_lo_d;
      rdata_q       <= rdata_d;
      overflow_q    <= overflow_d;
      rd_err_q      <= rd_err_d;
      txn_q         <= txn_d;
    end
  end

  assign OP_VALID           = (count_q != '0);
  assign OP_RW              = OP_VALID ? head.rw    : 1'b1;
  assign OP_ADDR            = OP_VALID ? head.addr  : 24'h0;
  assign OP_WDATA           = OP_VALID ? head.wdata : 16'h0;
  assign OP_UDS_n           = OP_VALID ? head.uds_n : 1'b1;
  assign OP_LDS_n           = OP_VALID ? head.lds_n : 1'b1;
  assign PI_TXN_IN_PROGRESS = txn_q;

  assign status  = {IPL_IN, overflow_q, count_q == CW'(DEPTH), count_q == '0,
                    rd_err_q, 1'b0, 8'(count_q)};
  assign PI_D_OE = PI_RD && (PI_A == A_DATA || PI_A == A_STATUS);

  always_comb begin
    PI_D_OUT = 16'h0;
    case (PI_A)
      A_DATA:   PI_D_OUT = rdata_q;
      A_STATUS: PI_D_OUT = status;
      default:  PI_D_OUT = 16'h0;
    endcase
  end
endmodule

// File: tb/tb_pi_cmd_queue.sv
// Directed bench for pi_cmd_queue: Pi register writes in, sequencer beats out,
// status and read data checked against hand-computed values.
`timescale 1ns/1ps
module tb_pi_cmd_queue;
  localparam int DEPTH = 4;

  logic        PI_CLK = 1'b0;
  logic        PI_RESET_n = 1'b0;
  logic [1:0]  PI_A = 2'd0;
  logic        PI_RD = 1'b0;
  logic        PI_WR = 1'b0;
  logic [15:0] PI_D_IN = 16'h0;
  logic [15:0] PI_D_OUT;
  logic        PI_D_OE;
  logic        PI_TXN_IN_PROGRESS;
  logic [2:0]  IPL_IN = 3'd0;
  logic        OP_VALID;
  logic        OP_READY = 1'b0;
  logic        OP_RW;
  logic [23:0] OP_ADDR;
  logic [15:0] OP_WDATA;
  logic        OP_UDS_n;
  logic        OP_LDS_n;
  logic        RD_DONE = 1'b0;
  logic [15:0] RD_DATA = 16'h0;

  pi_cmd_queue #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .PI_CLK(PI_CLK), .PI_RESET_n(PI_RESET_n), .PI_A(PI_A), .PI_RD(PI_RD),
    .PI_WR(PI_WR), .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE),
    .PI_TXN_IN_PROGRESS(PI_TXN_IN_PROGRESS), .IPL_IN(IPL_IN),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_RW(OP_RW), .OP_ADDR(OP_ADDR),
    .OP_WDATA(OP_WDATA), .OP_UDS_n(OP_UDS_n), .OP_LDS_n(OP_LDS_n),
    .RD_DONE(RD_DONE), .RD_DATA(RD_DATA)
  );

  always #2.5 PI_CLK = ~PI_CLK;

  int          total = 0;
  int          bad = 0;
  logic [42:0] beats[$];
  logic        txn_seen = 1'b0;
  logic        toggle_en = 1'b0;
  logic [15:0] rd_val;

  // Beats are recorded half a cycle before the edge that transfers them.
  always @(negedge PI_CLK) begin
    if (PI_RESET_n && OP_VALID && OP_READY)
      beats.push_back({OP_ADDR, OP_WDATA, OP_RW, OP_UDS_n, OP_LDS_n});
    if (PI_TXN_IN_PROGRESS) txn_seen = 1'b1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PI_CLK);
      #1;
      if (toggle_en) OP_READY = ~OP_READY;
    end
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
    tick(4);
    PI_WR = 1'b0;
    tick(4);
  endtask

  task automatic pi_read(input logic [1:0] a, output logic [15:0] d);
    PI_A = a; PI_RD = 1'b1;
    #0.25 d = PI_D_OUT;
    #0.25 PI_RD = 1'b0;
  endtask

  task automatic rd_done_pulse(input logic [15:0] d);
    RD_DATA = d; RD_DONE = 1'b1;
    tick(1);
    RD_DONE = 1'b0;
    tick(1);
  endtask

  function automatic logic [15:0] stat(input logic ovf, input logic full, input logic empty,
                                       input logic err, input logic [7:0] cnt);
    return {IPL_IN, ovf, full, empty, err, 1'b0, cnt};
  endfunction

  function automatic logic [42:0] beat(input logic [23:0] addr, input logic [15:0] wd,
                                       input logic rw, input logic u, input logic l);
    return {addr, wd, rw, u, l};
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] lo;
    // Reset state
    tick(3);
    check_val("rst op_valid", OP_VALID, 0);
    check_val("rst op_rw", OP_RW, 1);
    check_val("rst strobes", {OP_UDS_n, OP_LDS_n}, 2'b11);
    check_val("rst txn", PI_TXN_IN_PROGRESS, 0);
    pi_read(2'd3, rd_val);
    check_val("rst status", rd_val, 16'h0400);
    PI_RESET_n = 1'b1;
    tick(2);

    // Reset asserted while a pushed command is pending
    pi_write(2'd0, 16'h1111);
    pi_write(2'd1, 16'h2222);
    PI_A = 2'd2; PI_D_IN = 16'h0; PI_WR = 1'b1;
    tick(5);
    check_val("pre-reset op_valid", OP_VALID, 1);
    #0.5 PI_RESET_n = 1'b0;
    #0.5;
    check_val("mid reset op_valid", OP_VALID, 0);
    check_val("mid reset op_rw", OP_RW, 1);
    check_val("mid reset strobes", {OP_UDS_n, OP_LDS_n}, 2'b11);
    check_val("mid reset txn", PI_TXN_IN_PROGRESS, 0);
    pi_read(2'd3, rd_val);
    check_val("mid reset count", rd_val[7:0], 8'h0);
    PI_WR = 1'b0;
    tick(3);
    PI_RESET_n = 1'b1;
    tick(3);

    // Word write drained immediately
    OP_READY = 1'b1; beats.delete(); txn_seen = 1'b0;
    pi_write(2'd0, 16'hBEEF);
    pi_write(2'd1, 16'h1234);
    pi_write(2'd2, 16'h0000);
    tick(4);
    check_val("word beats", beats.size(), 1);
    if (beats.size() > 0) check_val("word beat", beats[0], beat(24'h001234, 16'hBEEF, 0, 0, 0));
    check_val("word txn never", txn_seen, 0);

    // Byte read, odd address
    beats.delete();
    pi_write(2'd1, 16'h0101);
    pi_write(2'd2, 16'h0312);
    tick(2);
    check_val("byte rd beats", beats.size(), 1);
    if (beats.size() > 0) check_val("byte rd beat", beats[0], beat(24'h120101, 16'hBEEF, 1, 1, 0));
    check_val("byte rd txn", PI_TXN_IN_PROGRESS, 1);
    rd_done_pulse(16'h00A5);
    check_val("rd done txn", PI_TXN_IN_PROGRESS, 0);
    pi_read(2'd0, rd_val);
    check_val("data read", rd_val, 16'h00A5);
    PI_A = 2'd0; PI_RD = 1'b1; #0.25;
    check_val("oe data", PI_D_OE, 1);
    PI_A = 2'd1; #0.25;
    check_val("oe addr_lo", PI_D_OE, 0);
    check_val("dout addr_lo", PI_D_OUT, 16'h0);
    PI_RD = 1'b0;
    tick(1);

    // Fill past DEPTH with the sequencer stalled
    OP_READY = 1'b0; beats.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      pi_write(2'd0, 16'h5500 + 16'(i));
      pi_write(2'd1, 16'h1000 + 16'(i));
      pi_write(2'd2, 16'h0000);
      if (i == DEPTH - 1) begin
        pi_read(2'd3, rd_val);
        check_val("full no ovf", rd_val, stat(0, 1, 0, 0, 8'(DEPTH)));
      end
    end
    pi_read(2'd3, rd_val);
    check_val("full ovf", rd_val, stat(1, 1, 0, 0, 8'(DEPTH)));
    check_val("full txn", PI_TXN_IN_PROGRESS, 1);
    OP_READY = 1'b1;
    tick(8);
    OP_READY = 1'b0;
    check_val("full drain beats", beats.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < beats.size(); i++) begin
      lo = 16'h1000 + 16'(i);
      check_val($sformatf("full beat%0d", i), beats[i], beat({8'h00, lo}, 16'h5500 + 16'(i), 0, 0, 0));
    end
    pi_read(2'd3, rd_val);
    check_val("drained ovf sticky", rd_val, stat(1, 0, 1, 0, 0));
    pi_write(2'd3, 16'h0001);
    pi_read(2'd3, rd_val);
    check_val("ovf cleared", rd_val, stat(0, 0, 1, 0, 0));

    // Pointer wrap with a stuttering sequencer
    beats.delete();
    pi_write(2'd0, 16'h7777);
    toggle_en = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      pi_write(2'd1, 16'h2000 + 16'(i));
      pi_write(2'd2, 16'h0000);
    end
    toggle_en = 1'b0;
    OP_READY = 1'b1;
    tick(4);
    OP_READY = 1'b0;
    check_val("wrap beats", beats.size(), 3 * DEPTH);
    for (int i = 0; i < 3 * DEPTH && i < beats.size(); i++) begin
      lo = 16'h2000 + 16'(i);
      check_val($sformatf("wrap beat%0d", i), beats[i], beat({8'h00, lo}, 16'h7777, 0, 0, 0));
    end
    pi_read(2'd3, rd_val);
    check_val("wrap status", rd_val, stat(0, 0, 1, 0, 0));

    // Push and pop on the same edge while full
    beats.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pi_write(2'd1, 16'h3000 + 16'(i));
      pi_write(2'd2, 16'h0000);
    end
    pi_write(2'd1, 16'h3000 + 16'(DEPTH));
    PI_A = 2'd2; PI_D_IN = 16'h0000; PI_WR = 1'b1;
    tick(2);
    OP_READY = 1'b1;
    tick(1);
    OP_READY = 1'b0;
    tick(2);
    PI_WR = 1'b0;
    tick(4);
    pi_read(2'd3, rd_val);
    check_val("push+pop status", rd_val, stat(0, 1, 0, 0, 8'(DEPTH)));
    check_val("push+pop beats", beats.size(), 1);
    OP_READY = 1'b1;
    tick(8);
    OP_READY = 1'b0;
    check_val("push+pop drain", beats.size(), DEPTH + 1);
    for (int i = 0; i <= DEPTH && i < beats.size(); i++) begin
      lo = 16'h3000 + 16'(i);
      check_val($sformatf("push+pop beat%0d", i), beats[i], beat({8'h00, lo}, 16'h7777, 0, 0, 0));
    end

    // Flush with two queued reads and one in flight
    pi_write(2'd1, 16'h4000);
    pi_write(2'd2, 16'h0200);
    OP_READY = 1'b1;
    tick(1);
    OP_READY = 1'b0;
    tick(1);
    pi_write(2'd2, 16'h0200);
    pi_write(2'd2, 16'h0200);
    pi_read(2'd3, rd_val);
    check_val("pre-flush status", rd_val, stat(0, 0, 0, 0, 2));
    check_val("pre-flush txn", PI_TXN_IN_PROGRESS, 1);
    pi_write(2'd3, 16'h8000);
    pi_read(2'd3, rd_val);
    check_val("flush status", rd_val, stat(0, 0, 1, 0, 0));
    check_val("flush op_valid", OP_VALID, 0);
    check_val("flush txn held", PI_TXN_IN_PROGRESS, 1);
    rd_done_pulse(16'h1111);
    check_val("flush txn released", PI_TXN_IN_PROGRESS, 0);
    pi_read(2'd3, rd_val);
    check_val("flush no rd_err", rd_val, stat(0, 0, 1, 0, 0));

    // Spurious completion
    IPL_IN = 3'd5;
    rd_done_pulse(16'h2222);
    pi_read(2'd3, rd_val);
    check_val("spurious rd_err", rd_val, 16'hA600);
    pi_read(2'd0, rd_val);
    check_val("spurious rdata", rd_val, 16'h2222);
    pi_write(2'd3, 16'h0002);
    pi_read(2'd3, rd_val);
    check_val("rd_err cleared", rd_val, 16'hA400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
